nibble_serial_adder: RTL and testbench

- Multi-cycle W-bit adder/subtractor that processes one nibble per clock through a single instantiated 4-bit ripple-carry adder (_4bit_rca).
- Registers the inter-nibble carry between cycles, so one 4-bit adder handles wide operands.
- Upstream sequencer for the 4-bit adder stage: drives its a/b/c_in and consumes its s/c_out.
- Used where area matters more than latency in the ALU.

---
 rtl/nibble_serial_adder.sv | 167 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Purpose : W-bit add/subtract computed one nibble per clock through a single 4-bit ripple-carry adder.
// Latency : start accepted at edge T -> busy for cycles T+1..T+NIBBLES, done pulse and result in T+NIBBLES+1.
// Backpr. : none; start is ignored while busy, so the caller retries in IDLE or the DONE cycle.
// Ports   : clk, rst_n (sync, active-low) | start, sub, a, b, c_in (captured on accept)
//           busy, done (1-cycle pulse) | s, c_out, overflow (hold until the next completion)
module nibble_serial_adder #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         c_out,
    output logic         overflow
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    s_q, s_d;
    logic            carry_q, carry_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [3:0]      rca_a, rca_b, rca_s;
    logic            rca_co;

    _4bit_rca u_rca (
        .a     (rca_a),
        .b     (rca_b),
        .c_in  (carry_q),
        .s     (rca_s),
        .c_out (rca_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            work_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            work_q  <= work_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        work_d  = work_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        rca_a   = '0;
        rca_b   = '0;
        busy    = 1'b0;
        done    = 1'b0;

        // Nibble mux built from constant slices so every select is static.
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDXW'(n)) begin
                rca_a = opa_q[4*n +: 4];
                rca_b = opb_q[4*n +: 4];
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    // Subtract as a + ~b + ~borrow, so the adder only ever adds.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? ~c_in : c_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        work_d[4*n +: 4] = rca_s;
                    end
                end
                carry_d = rca_co;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    // Publish the whole word at once, last nibble included.
                    s_d     = work_d;
                    c_out_d = rca_co;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (rca_s[3] != opa_q[W-1]);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s        = s_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// Purpose : 4-bit ripple-carry adder, one full-adder cell per bit.
// Latency : purely combinational.
// Backpr. : none.
module _4bit_rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[4];

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_out;
    logic         overflow;

    int passed = 0;
    int total  = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic         vcin;
        logic [W-1:0] exp_s;
        logic         exp_c;
        logic         exp_v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands as numbers.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic msub, input logic mcin,
                                  output logic [W-1:0] rs, output logic rc, output logic rv);
        int r;
        int sr;
        if (!msub) begin
            r  = int'(ma) + int'(mb) + int'(mcin);
            sr = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
            rc = (r > 65535);
        end else begin
            r  = int'(ma) - int'(mb) - int'(mcin);
            sr = int'($signed(ma)) - int'($signed(mb)) - int'(mcin);
            rc = (r >= 0);
        end
        rs = r[W-1:0];
        rv = (sr > 32767) || (sr < -32768);
    endfunction

    // Called just after a negedge with the DUT in IDLE; returns one cycle after the done pulse.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsub, input logic tcin,
                          output logic [W-1:0] rs, output logic rc, output logic rv);
        a = ta; b = tb_v; sub = tsub; c_in = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs during RUN; they must not matter.
        a    = 16'($urandom);
        b    = 16'($urandom);
        sub  = 1'($urandom_range(0, 1));
        c_in = 1'($urandom_range(0, 1));
        for (int k = 1; k <= NIB; k++) begin
            check({tag, " busy_run"}, busy, 1);
            check({tag, " done_run"}, done, 0);
            @(negedge clk);
        end
        check({tag, " done_pulse"}, done, 1);
        check({tag, " busy_done"}, busy, 0);
        rs = s; rc = c_out; rv = overflow;
        @(negedge clk);
        check({tag, " done_after"}, done, 0);
    endtask

    vec_t vecs[8];
    logic [W-1:0] got_s, ref_s, ra, rb;
    logic         got_c, got_v, ref_c, ref_v, rsub, rcin;

    initial begin
        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;
        @(negedge clk);
        start = 1'b1;          // reset must win over start
        a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst s", s, 0);
        check("rst c_out", c_out, 0);
        check("rst overflow", overflow, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", busy, 0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin,
                   got_s, got_c, got_v);
            check($sformatf("vec%0d s", i), got_s, vecs[i].exp_s);
            check($sformatf("vec%0d c_out", i), got_c, vecs[i].exp_c);
            check($sformatf("vec%0d ovf", i), got_v, vecs[i].exp_v);
        end

        // start re-pulsed during RUN is ignored
        a = 16'h1234; b = 16'h0FCD; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);                                  // T+1
        start = 1'b0;
        @(negedge clk);                                  // T+2
        start = 1'b1; a = 16'hFFFF; b = 16'h0001; sub = 1'b1; c_in = 1'b1;
        @(negedge clk);                                  // T+3
        start = 1'b0;
        @(negedge clk);                                  // T+4
        check("repulse busy", busy, 1);
        @(negedge clk);                                  // T+5
        check("repulse done", done, 1);
        check("repulse s", s, 16'h2201);
        check("repulse c_out", c_out, 0);
        check("repulse ovf", overflow, 0);
        @(negedge clk);                                  // T+6
        check("repulse no_second_op busy", busy, 0);
        check("repulse no_second_op done", done, 0);

        // Back-to-back: start in the DONE cycle
        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);                                  // T+1
        start = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);     // T+5
        check("b2b done1", done, 1);
        check("b2b s1", s, 16'h8000);
        check("b2b ovf1", overflow, 1);
        a = 16'h8000; b = 16'h0001; sub = 1'b1; c_in = 1'b0; start = 1'b1;
        @(negedge clk);                                  // T+6
        start = 1'b0;
        check("b2b busy2", busy, 1);
        check("b2b done_gap", done, 0);
        check("b2b s_hold", s, 16'h8000);
        for (int k = 7; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("b2b done_T%0d", k), done, 0);
        end
        @(negedge clk);                                  // T+10
        check("b2b done2", done, 1);
        check("b2b s2", s, 16'h7FFF);
        check("b2b c_out2", c_out, 1);
        check("b2b ovf2", overflow, 1);
        @(negedge clk);
        check("b2b done2_after", done, 0);

        // Reset in the middle of RUN
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);                                  // T+1
        start = 1'b0;
        @(negedge clk);                                  // T+2
        rst_n = 1'b0;
        @(negedge clk);                                  // T+3
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst s", s, 0);
        check("midrst c_out", c_out, 0);
        check("midrst ovf", overflow, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("midrst idle_done%0d", k), done, 0);
            check($sformatf("midrst idle_busy%0d", k), busy, 0);
        end

        // Randomised against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            if (i % 8 == 0) ra = 16'hFFFF;
            if (i % 8 == 1) rb = 16'h8000;
            model(ra, rb, rsub, rcin, ref_s, ref_c, ref_v);
            run_op($sformatf("rnd%0d", i), ra, rb, rsub, rcin, got_s, got_c, got_v);
            check($sformatf("rnd%0d s", i), got_s, ref_s);
            check($sformatf("rnd%0d c_out", i), got_c, ref_c);
            check($sformatf("rnd%0d ovf", i), got_v, ref_v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
